game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Top-level game sequencer for the brick game. It runs the round state machine (idle, serve, play, pause, lost, over, win) and tracks lives. It generates the physics tick that paces the ball datapath. It also owns the paddle's control byte, muxing either the player joystick byte or a built-in auto-track control derived from ball and paddle x positions. Sits between input/ADC logic and the paddle/ball datapath.

Parameters:
TICK_DIV, 100000, clk cycles per physics tick (>= 2)
LIVES, 3, lives loaded at game start (1..7)
SERVE_TICKS, 120, ticks spent in SERVE before PLAY (>= 1)
DEADZONE, 4, auto-track |dx| at or below which paddle is held still
FAST_ZONE, 40, auto-track |dx| above which fast move is requested (> DEADZONE)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
start_btn  input  1  start button, level, synchronous to clk
pause_btn  input  1  pause toggle button, level, synchronous to clk
auto_mode  input  1  1 = auto-track drives paddle, 0 = joystick drives paddle
joy_ctrl  input  8  player control byte, 0x80 = neutral
ball_x  input  11  ball x position, pixels
x_paddle  input  11  paddle x position from paddle block
ball_lost  input  1  one-cycle pulse when ball passes below paddle
bricks_left  input  8  remaining brick count
paddle_ctrl  output  8  control byte to paddle block
paddle_rst_n  output  1  active-low paddle recentre strobe
tick  output  1  one-cycle physics tick pulse, PLAY only
state  output  3  IDLE=0 SERVE=1 PLAY=2 PAUSE=3 LOST=4 OVER=5 WIN=6
lives  output  3  lives remaining

Behaviour:
- Reset (rst low, async): state=IDLE, lives=0, tick=0, paddle_ctrl=0x80, paddle_rst_n=1, tick counter=0, serve counter=0, button history regs=0.
- Buttons: rising-edge detected with one history register each. Rise = cur & ~prev. A held level never retriggers.
- Tick counter counts 0..TICK_DIV-1 in SERVE and PLAY, then wraps. It holds its value in PAUSE and clears to 0 in all other states. Wrap from TICK_DIV-1 to 0 is the "tick event". The tick output is registered high for the cycle after the event, only when the state is PLAY.
- IDLE: start rise -> SERVE, lives <= LIVES.
- SERVE:
  - On the entry cycle, paddle_rst_n is driven low for exactly one cycle (registered), and the serve counter is cleared.
  - Each tick event increments the serve counter. When it reaches SERVE_TICKS -> PLAY.
  - Pause and start are ignored.
- PLAY: priority is bricks_left==0 -> WIN, then ball_lost -> LOST, then pause rise -> PAUSE. Start is ignored.
- PAUSE: pause rise -> PLAY, with the tick counter resuming from its held value. ball_lost is ignored.
- LOST: single-cycle state. lives <= lives-1.
  - Next state is OVER if the pre-decrement lives was 1, else SERVE.
- OVER, WIN: hold. Start rise -> IDLE, and lives is preserved for display until the next game start.
- paddle_ctrl: registered, 1-cycle latency from inputs. Outside PLAY it is 0x80.
- In PLAY with auto_mode=0, it equals joy_ctrl.
- In PLAY with auto_mode=1: d = ball_x - x_paddle, computed as 12-bit signed (zero-extend both operands).
  - d > FAST_ZONE -> 0xE0
  - d > DEADZONE -> 0xA0
  - d < -FAST_ZONE -> 0x20
  - d < -DEADZONE -> 0x60
  - else 0x80
  - These bytes decode to paddle dx of +2, +1, -2, -1 and 0.
- auto_mode may change at any cycle. The new source takes effect on the next paddle_ctrl register update.
- lives never underflows: LOST is reachable only with lives >= 1.
- Reset asserted mid-game returns every output to its reset value immediately, regardless of state.

Test Plan:
1. Reset, then start rise (TICK_DIV=4, SERVE_TICKS=2) -> state goes 0->1, lives=3, paddle_rst_n low exactly one cycle, state=2 after 8 cycles in SERVE, then tick pulses every 4 cycles.
2. In PLAY, auto_mode=1, x_paddle=400, ball_x = 450/420/402/380/300 -> paddle_ctrl = 0xE0/0xA0/0x80/0x60/0x20 one cycle later. auto_mode=0, joy_ctrl=0x33 -> 0x33.
3. ball_lost pulse in PLAY with lives=3 -> LOST for one cycle, lives=2, SERVE with recentre strobe. Repeat until lives=1 -> lost -> OVER, lives=0, paddle_ctrl=0x80.
4. ball_lost and bricks_left==0 in the same PLAY cycle -> WIN, lives unchanged. Then start rise -> IDLE.
5. Pause rise at tick counter=2 -> PAUSE, no tick pulses and counter frozen while pause_btn is held high for 50 cycles. Release, then a second rise -> PLAY, with the next tick after 2 cycles.
6. Assert rst mid-PLAY and mid-SERVE -> state=0, lives=0, tick=0, paddle_ctrl=0x80 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : game_ctrl
// Brief   : Brick-game round sequencer. Tracks lives, paces the physics tick
//           and drives the paddle control byte (joystick or auto-track).
// Revision: 1.0 - initial release
// ============================================================================
module game_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int LIVES       = 3,
  parameter int SERVE_TICKS = 120,
  parameter int DEADZONE    = 4,
  parameter int FAST_ZONE   = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        auto_mode,
  input  logic [7:0]  joy_ctrl,
  input  logic [10:0] ball_x,
  input  logic [10:0] x_paddle,
  input  logic        ball_lost,
  input  logic [7:0]  bricks_left,
  output logic [7:0]  paddle_ctrl,
  output logic        paddle_rst_n,
  output logic        tick,
  output logic [2:0]  state,
  output logic [2:0]  lives
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LOST  = 3'd4,
    ST_OVER  = 3'd5,
    ST_WIN   = 3'd6
  } state_t;

  localparam int c_tick_w  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int c_serve_w = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam logic [c_tick_w-1:0]  c_tick_max   = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_serve_w-1:0] c_serve_last = c_serve_w'(SERVE_TICKS - 1);
  localparam logic [2:0]           c_lives_init = 3'(LIVES);
  localparam logic signed [11:0]   c_fast_p     = 12'(FAST_ZONE);
  localparam logic signed [11:0]   c_fast_n     = 12'(-FAST_ZONE);
  localparam logic signed [11:0]   c_dead_p     = 12'(DEADZONE);
  localparam logic signed [11:0]   c_dead_n     = 12'(-DEADZONE);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [2:0]             r_lives;
  logic [2:0]             w_next_lives;
  logic [c_tick_w-1:0]    r_tick_cnt;
  logic [c_serve_w-1:0]   r_serve_cnt;
  logic                   r_start_prev;
  logic                   r_pause_prev;
  logic                   r_tick;
  logic [7:0]             r_paddle_ctrl;
  logic                   r_paddle_rst_n;
  logic                   w_start_rise;
  logic                   w_pause_rise;
  logic                   w_running;
  logic                   w_tick_evt;
  logic signed [11:0]     w_dx;
  logic [7:0]             w_auto_ctrl;
  logic [7:0]             w_next_ctrl;

  assign w_start_rise = start_btn & ~r_start_prev;
  assign w_pause_rise = pause_btn & ~r_pause_prev;
  assign w_running    = (r_state == ST_SERVE) || (r_state == ST_PLAY);
  assign w_tick_evt   = w_running && (r_tick_cnt == c_tick_max);

  // Both operands zero-extended so the 12-bit difference cannot overflow.
  assign w_dx = $signed({1'b0, ball_x}) - $signed({1'b0, x_paddle});

  always_comb begin
    w_auto_ctrl = 8'h80;
    if (w_dx > c_fast_p)       w_auto_ctrl = 8'hE0;
    else if (w_dx > c_dead_p)  w_auto_ctrl = 8'hA0;
    else if (w_dx < c_fast_n)  w_auto_ctrl = 8'h20;
    else if (w_dx < c_dead_n)  w_auto_ctrl = 8'h60;
  end

  always_comb begin
    w_next_ctrl = 8'h80;
    if (r_state == ST_PLAY) begin
      w_next_ctrl = auto_mode ? w_auto_ctrl : joy_ctrl;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_lives = r_lives;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_next_state = ST_SERVE;
          w_next_lives = c_lives_init;
        end
      end
      ST_SERVE: begin
        if (w_tick_evt && (r_serve_cnt == c_serve_last)) w_next_state = ST_PLAY;
      end
      ST_PLAY: begin
        if (bricks_left == 8'd0)  w_next_state = ST_WIN;
        else if (ball_lost)       w_next_state = ST_LOST;
        else if (w_pause_rise)    w_next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_pause_rise) w_next_state = ST_PLAY;
      end
      ST_LOST: begin
        if (r_lives != 3'd0) w_next_lives = r_lives - 3'd1;
        w_next_state = (r_lives <= 3'd1) ? ST_OVER : ST_SERVE;
      end
      ST_OVER, ST_WIN: begin
        if (w_start_rise) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_lives        <= 3'd0;
      r_tick_cnt     <= '0;
      r_serve_cnt    <= '0;
      r_start_prev   <= 1'b0;
      r_pause_prev   <= 1'b0;
      r_tick         <= 1'b0;
      r_paddle_ctrl  <= 8'h80;
      r_paddle_rst_n <= 1'b1;
    end else begin
      r_state       <= w_next_state;
      r_lives       <= w_next_lives;
      r_start_prev  <= start_btn;
      r_pause_prev  <= pause_btn;
      r_tick        <= w_tick_evt && (r_state == ST_PLAY);
      r_paddle_ctrl <= w_next_ctrl;
      // Recentre strobe is low only on the first cycle spent in SERVE.
      r_paddle_rst_n <= !((w_next_state == ST_SERVE) && (r_state != ST_SERVE));

      if (w_running) begin
        r_tick_cnt <= w_tick_evt ? '0 : r_tick_cnt + 1'b1;
      end else if (r_state != ST_PAUSE) begin
        r_tick_cnt <= '0;
      end

      if (r_state != ST_SERVE) begin
        r_serve_cnt <= '0;
      end else if (w_tick_evt) begin
        r_serve_cnt <= r_serve_cnt + 1'b1;
      end
    end
  end

  assign paddle_ctrl  = r_paddle_ctrl;
  assign paddle_rst_n = r_paddle_rst_n;
  assign tick         = r_tick;
  assign state        = r_state;
  assign lives        = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_ctrl
// Brief   : Self-checking bench for game_ctrl: vector table, directed round
//           sequences and randomized traffic against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

  localparam int TD = 4;
  localparam int NL = 3;
  localparam int ST = 2;
  localparam int DZ = 4;
  localparam int FZ = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn, pause_btn, auto_mode, ball_lost;
  logic [7:0]  joy_ctrl, bricks_left;
  logic [10:0] ball_x, x_paddle;
  logic [7:0]  paddle_ctrl;
  logic        paddle_rst_n, tick;
  logic [2:0]  state, lives;

  int total = 0;
  int bad   = 0;

  game_ctrl #(
    .TICK_DIV(TD), .LIVES(NL), .SERVE_TICKS(ST), .DEADZONE(DZ), .FAST_ZONE(FZ)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .auto_mode(auto_mode), .joy_ctrl(joy_ctrl), .ball_x(ball_x),
    .x_paddle(x_paddle), .ball_lost(ball_lost), .bricks_left(bricks_left),
    .paddle_ctrl(paddle_ctrl), .paddle_rst_n(paddle_rst_n), .tick(tick),
    .state(state), .lives(lives)
  );

  always #5 clk = ~clk;

  // Reference model: round rules expressed with plain integers.
  int m_state, m_lives, m_pctl, m_prst, m_tick, m_tcnt, m_scnt, m_sp, m_pp;

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_pctl = 'h80; m_prst = 1; m_tick = 0;
    m_tcnt = 0; m_scnt = 0; m_sp = 0; m_pp = 0;
  endtask

  function automatic int auto_byte(int bx, int px);
    int d = bx - px;
    if (d > FZ) return 'hE0;
    if (d > DZ) return 'hA0;
    if (d < -FZ) return 'h20;
    if (d < -DZ) return 'h60;
    return 'h80;
  endfunction

  task automatic model_step();
    int  ns, nl;
    bit  sr, pr, ev, run;
    sr  = start_btn && (m_sp == 0);
    pr  = pause_btn && (m_pp == 0);
    run = (m_state == 1) || (m_state == 2);
    ev  = run && (m_tcnt == TD - 1);
    ns = m_state; nl = m_lives;
    case (m_state)
      0: if (sr) begin ns = 1; nl = NL; end
      1: if (ev && (m_scnt + 1 == ST)) ns = 2;
      2: if (bricks_left == 0) ns = 6; else if (ball_lost) ns = 4; else if (pr) ns = 3;
      3: if (pr) ns = 2;
      4: begin nl = m_lives - 1; ns = (m_lives == 1) ? 5 : 1; end
      default: if (sr) ns = 0;
    endcase
    if (m_state == 2) m_pctl = auto_mode ? auto_byte(int'(ball_x), int'(x_paddle)) : int'(joy_ctrl);
    else m_pctl = 'h80;
    m_prst = (ns == 1 && m_state != 1) ? 0 : 1;
    m_tick = (ev && m_state == 2) ? 1 : 0;
    if (run) m_tcnt = ev ? 0 : m_tcnt + 1;
    else if (m_state != 3) m_tcnt = 0;
    if (m_state != 1) m_scnt = 0;
    else if (ev) m_scnt = m_scnt + 1;
    m_sp = start_btn; m_pp = pause_btn;
    m_state = ns; m_lives = nl;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_state", 32'(state), m_state);
    chk("m_lives", 32'(lives), m_lives);
    chk("m_tick", 32'(tick), m_tick);
    chk("m_paddle_ctrl", 32'(paddle_ctrl), m_pctl);
    chk("m_paddle_rst_n", 32'(paddle_rst_n), m_prst);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(state) != s && n < budget) begin cyc(); n++; end
    chk("reach_state", 32'(state), s);
  endtask

  task automatic start_game();
    start_btn = 1'b0; cyc();
    start_btn = 1'b1; cyc();
    start_btn = 1'b0;
  endtask

  task automatic areset();
    #2 rst = 1'b0;
    #1;
    chk("ar_state", 32'(state), 0);
    chk("ar_lives", 32'(lives), 0);
    chk("ar_tick", 32'(tick), 0);
    chk("ar_paddle_ctrl", 32'(paddle_ctrl), 'h80);
    chk("ar_paddle_rst_n", 32'(paddle_rst_n), 1);
    model_reset();
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [10:0] bx;
    logic [10:0] px;
    logic        am;
    logic [7:0]  joy;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{11'd450, 11'd400, 1'b1, 8'h00, 8'hE0};
    vt[1]  = '{11'd420, 11'd400, 1'b1, 8'h00, 8'hA0};
    vt[2]  = '{11'd402, 11'd400, 1'b1, 8'h00, 8'h80};
    vt[3]  = '{11'd380, 11'd400, 1'b1, 8'h00, 8'h60};
    vt[4]  = '{11'd300, 11'd400, 1'b1, 8'h00, 8'h20};
    vt[5]  = '{11'd400, 11'd400, 1'b0, 8'h33, 8'h33};
    vt[6]  = '{11'd440, 11'd400, 1'b1, 8'h00, 8'hA0};
    vt[7]  = '{11'd441, 11'd400, 1'b1, 8'h00, 8'hE0};
    vt[8]  = '{11'd404, 11'd400, 1'b1, 8'h00, 8'h80};
    vt[9]  = '{11'd405, 11'd400, 1'b1, 8'h00, 8'hA0};
    vt[10] = '{11'd396, 11'd400, 1'b1, 8'h00, 8'h80};
    vt[11] = '{11'd360, 11'd400, 1'b1, 8'h00, 8'h60};
    vt[12] = '{11'd359, 11'd400, 1'b1, 8'h00, 8'h20};
    vt[13] = '{11'd0,   11'd2047, 1'b1, 8'h00, 8'h20};

    start_btn = 0; pause_btn = 0; auto_mode = 0; ball_lost = 0;
    joy_ctrl = 8'h80; bricks_left = 8'd50; ball_x = 11'd400; x_paddle = 11'd400;
    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_lives", 32'(lives), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_paddle_ctrl", 32'(paddle_ctrl), 'h80);
    chk("rst_paddle_rst_n", 32'(paddle_rst_n), 1);
    rst = 1'b1;
    cyc();

    // Game start, recentre strobe, SERVE length, tick cadence.
    start_btn = 1'b1; cyc();
    chk("serve_entry", 32'(state), 1);
    chk("serve_lives", 32'(lives), 3);
    chk("strobe_low", 32'(paddle_rst_n), 0);
    cyc();
    chk("strobe_high", 32'(paddle_rst_n), 1);
    start_btn = 1'b0;
    repeat (6) cyc();
    chk("serve_hold", 32'(state), 1);
    cyc();
    chk("play_entry", 32'(state), 2);
    for (int k = 0; k < 2; k++) begin
      repeat (3) begin cyc(); chk("tick_low", 32'(tick), 0); end
      cyc(); chk("tick_pulse", 32'(tick), 1);
    end

    // Paddle control byte table.
    for (int i = 0; i < 14; i++) begin
      ball_x = vt[i].bx; x_paddle = vt[i].px; auto_mode = vt[i].am; joy_ctrl = vt[i].joy;
      cyc();
      chk($sformatf("vec%0d_paddle_ctrl", i), 32'(paddle_ctrl), 32'(vt[i].exp));
    end
    auto_mode = 1'b0; joy_ctrl = 8'h80;

    // Lose every life.
    for (int l = 3; l >= 1; l--) begin
      ball_lost = 1'b1; cyc(); ball_lost = 1'b0;
      chk("lost_state", 32'(state), 4);
      chk("lost_lives_pre", 32'(lives), l);
      cyc();
      if (l > 1) begin
        chk("reserve_state", 32'(state), 1);
        chk("reserve_lives", 32'(lives), l - 1);
        chk("reserve_strobe", 32'(paddle_rst_n), 0);
        wait_state(2, 20);
      end else begin
        chk("over_state", 32'(state), 5);
        chk("over_lives", 32'(lives), 0);
      end
    end
    cyc();
    chk("over_paddle_ctrl", 32'(paddle_ctrl), 'h80);

    // OVER -> IDLE, new game, simultaneous clear and loss -> WIN.
    start_game(); cyc();
    chk("idle_after_over", 32'(state), 0);
    chk("idle_lives_kept", 32'(lives), 0);
    start_game();
    chk("game2_lives", 32'(lives), 3);
    wait_state(2, 20);
    bricks_left = 8'd0; ball_lost = 1'b1; cyc();
    bricks_left = 8'd50; ball_lost = 1'b0;
    chk("win_state", 32'(state), 6);
    chk("win_lives", 32'(lives), 3);
    start_game();
    chk("idle_after_win", 32'(state), 0);

    // Pause with counter frozen while button held.
    start_game();
    wait_state(2, 20);
    cyc(); cyc();
    pause_btn = 1'b1; cyc();
    chk("pause_state", 32'(state), 3);
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("pause_no_tick", 32'(tick), 0);
      chk("pause_hold", 32'(state), 3);
    end
    pause_btn = 1'b0; cyc();
    pause_btn = 1'b1; cyc();
    chk("resume_state", 32'(state), 2);
    pause_btn = 1'b0; cyc();
    chk("resume_tick", 32'(tick), 1);

    // Asynchronous reset mid-PLAY and mid-SERVE.
    areset();
    start_game(); wait_state(2, 20); cyc();
    areset();
    start_game(); cyc(); cyc();
    chk("mid_serve", 32'(state), 1);
    areset();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      start_btn   = ($urandom_range(0, 7) == 0);
      pause_btn   = ($urandom_range(0, 15) == 0);
      ball_lost   = ($urandom_range(0, 47) == 0);
      bricks_left = ($urandom_range(0, 199) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      auto_mode   = 1'($urandom);
      joy_ctrl    = 8'($urandom);
      x_paddle    = 11'($urandom_range(100, 1900));
      ball_x      = 11'(int'(x_paddle) + $urandom_range(0, 120) - 60);
      if ($urandom_range(0, 499) == 0) areset();
      else cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
